imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
// - Write side of the CPU instruction memory: streams program words in over a valid/ready port and stores them in a DEPTH-entry imem.
// - Serves the CPU fetch port (pc -> instruction) combinationally.
// - Holds the CPU in reset until a complete, valid program is loaded, then releases it.
// - Sits between the bench/host program source and cpu; replaces the static initial_instructions array.
// PARAMETERS
// - DEPTH   32  number of 32-bit instruction words
// - ADDR_W  5   log2(DEPTH); word index width
// PORTS
// - clk         in   1         clock, rising edge
// - reset       in   1         asynchronous, active-high reset
// - load_start  in   1         1-cycle pulse: begin a new load
// - load_len    in   ADDR_W+1  program length in words, sampled with load_start
// - in_valid    in   1         in_data holds a word
// - in_ready    out  1         loader accepts a word this cycle
// - in_data     in   32        program word
// - pc          in   32        CPU fetch byte address
// - instruction out  32        fetched word
// - cpu_reset   out  1         drives cpu reset; 1 = CPU held
// - busy        out  1         load in progress
// - done        out  1         program loaded, CPU running
// - error       out  1         load rejected; sticky
// - word_count  out  ADDR_W+1  words accepted in the current load
// BEHAVIOUR
// - States: IDLE, LOAD, RUN, ERROR. All outputs are registered except instruction.
// - Reset (async): state=IDLE, all imem entries=0, word_count=0, in_ready=0, cpu_reset=1, busy=0, done=0, error=0.
// - IDLE: cpu_reset=1.
//   - load_start with 1<=load_len<=DEPTH -> LOAD: latch len, word_count=0, clear all imem entries to 0 at that edge.
//   - load_start with load_len==0 or load_len>DEPTH -> ERROR.
// - LOAD: busy=1, in_ready=1, cpu_reset=1.
//   - On in_valid&&in_ready: imem[word_count]<=in_data, word_count++.
//   - Gaps in in_valid are allowed; there is no timeout.
//   - The edge that accepts word len-1 -> RUN.
//   - load_start is ignored while in LOAD.
// - RUN: done=1, busy=0, in_ready=0. cpu_reset falls at the same edge that enters RUN.
//   - load_start with a valid length -> LOAD: cpu_reset rises, done falls, and imem is cleared at that edge (reload).
// - ERROR: error=1, cpu_reset=1, in_ready=0.
//   - Left only by reset or by load_start with a valid length (-> LOAD, error clears).
// - Fetch: instruction = imem[pc[ADDR_W+1:2]], zero latency, in every state; reflects writes from the following cycle.
//   - Returns 0 when pc[1:0]!=0 or pc >= DEPTH*4.
// - word_count saturates at len; it is never wider than ADDR_W+1.
// - Reset asserted mid-load aborts the load: imem is zeroed and state returns to IDLE immediately.
// CONFIGURATION
// - LOADER_CHECKSUM_EN defined:
//   - After len words, LOAD accepts one extra trailer word (in_ready stays 1).
//   - trailer == XOR of all len words -> RUN.
//   - Mismatch -> ERROR; imem contents are kept, CPU stays in reset.
//   - Running XOR register resets to 0 on reset and on each load_start.
// - LOADER_CHECKSUM_EN undefined:
//   - No trailer; RUN is entered on word len-1.
//   - error is raised only by an invalid load_len.
// TESTING
// - Basic load: load_len=3, words 0x005303b3, 0x40848533, 0x00160693.
//   - Expect cpu_reset falls on the 3rd acceptance edge, done=1.
//   - Fetch pc=0/4/8 returns the 3 words; pc=12 -> 0; pc=2 -> 0; pc=128 -> 0.
// - Backpressure: same program with in_valid low for 2 cycles between words.
//   - Expect identical imem, word_count steps 0->1->2->3, in_ready high throughout LOAD.
// - Bad length: load_start with load_len=0, then separately with 33.
//   - Expect error=1 and cpu_reset=1 the next cycle.
//   - A later load_start with load_len=1 clears error.
// - Reset mid-load: assert reset after 2 of 3 words.
//   - Expect all fetches return 0 immediately, state IDLE, cpu_reset=1, word_count=0.
// - Reload from RUN: load 1 word 0x00160693, then load_start again with load_len=1 and word 0x005303b3.
//   - Expect cpu_reset high during reload; pc=0 fetches 0x005303b3 afterwards.
// - LOADER_CHECKSUM_EN: basic-load program with trailer 0x40c18013.
//   - Expect RUN.
//   - With trailer 0x40c18012: expect error=1, cpu_reset=1.

Source files
------------

// File: rtl/imem_loader_if.sv
// Loader bundle: program stream in, CPU fetch port, status out.
// slave = loader side, master = host/bench side.
interface imem_loader_if #(
    parameter int ADDR_W = 5
);
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic [31:0]       pc;
    logic [31:0]       instruction;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    modport master (
        output load_start, load_len, in_valid, in_data, pc,
        input  in_ready, instruction, cpu_reset, busy, done, error, word_count
    );

    modport slave (
        input  load_start, load_len, in_valid, in_data, pc,
        output in_ready, instruction, cpu_reset, busy, done, error, word_count
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: streams words into imem, then releases the CPU.
// Stream accepted 1 word/cycle (in_ready registered, high for the whole load).
// Fetch is combinational. Optional trailer checksum: LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_ERROR} state_t;

    localparam logic [ADDR_W:0] DEPTH_W     = (ADDR_W+1)'(DEPTH);
    localparam logic [31:0]     FETCH_LIMIT = 32'(DEPTH * 4);

    state_t          state_q, state_d;
    logic [ADDR_W:0] len_q, len_d;
    logic [ADDR_W:0] word_count_q, word_count_d;
    logic            in_ready_q, in_ready_d;
    logic            cpu_reset_q, cpu_reset_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [31:0]     mem_q [DEPTH];
    logic [31:0]     mem_d [DEPTH];
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]     csum_q, csum_d;
`endif

    logic len_ok;
    logic accept;

    assign len_ok = (bus.load_len != '0) && (bus.load_len <= DEPTH_W);
    assign accept = bus.in_valid && in_ready_q;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_count_d = word_count_q;
        mem_d        = mem_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        case (state_q)
            S_LOAD: begin
                // load_start is deliberately ignored mid-load
                if (accept) begin
                    if (word_count_q != len_q) begin
                        mem_d[word_count_q[ADDR_W-1:0]] = bus.in_data;
                        word_count_d = word_count_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        csum_d = csum_q ^ bus.in_data;
                    end else if (bus.in_data == csum_q) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_ERROR;
                    end
`else
                        if (word_count_q == len_q - 1'b1) state_d = S_RUN;
                    end
`endif
                end
            end
            default: begin
                if (bus.load_start) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d = '0;
`endif
                    if (len_ok) begin
                        state_d      = S_LOAD;
                        len_d        = bus.load_len;
                        word_count_d = '0;
                        for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
                    end else if (state_q == S_IDLE) begin
                        state_d = S_ERROR;
                    end
                end
            end
        endcase

        // Status flags are registered copies of the next state
        in_ready_d  = (state_d == S_LOAD);
        busy_d      = (state_d == S_LOAD);
        done_d      = (state_d == S_RUN);
        error_d     = (state_d == S_ERROR);
        cpu_reset_d = (state_d != S_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            word_count_q <= '0;
            in_ready_q   <= 1'b0;
            cpu_reset_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_count_q <= word_count_d;
            in_ready_q   <= in_ready_d;
            cpu_reset_q  <= cpu_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            mem_q        <= mem_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.cpu_reset  = cpu_reset_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.word_count = word_count_q;

    // Misaligned or out-of-range fetches read as zero
    assign bus.instruction = ((bus.pc[1:0] == 2'b00) && (bus.pc < FETCH_LIMIT))
                             ? mem_q[bus.pc[ADDR_W+1:2]] : 32'h0;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load, backpressure, bad length, reset abort, reload.
module tb_imem_loader;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    imem_loader_if #(.ADDR_W(5)) bif ();

    imem_loader #(.DEPTH(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] W0 = 32'h005303b3;
    localparam logic [31:0] W1 = 32'h40848533;
    localparam logic [31:0] W2 = 32'h00160693;
    localparam logic [31:0] CSUM = 32'h40c18013;

    task automatic send_word(input logic [31:0] w);
        bit ok;
        ok = 1'b0;
        bif.in_data  = w;
        bif.in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (bif.in_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        bif.in_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout word=%08h in_ready never rose", w);
        end
    endtask

    task automatic pulse_start(input logic [5:0] len);
        bif.load_start = 1'b1;
        bif.load_len   = len;
        @(posedge clk); #1;
        bif.load_start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        bif.pc = 32'h0;
        #1;
        checks++; if (bif.cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset got=%b exp=1", bif.cpu_reset); end
        checks++; if (bif.busy !== 1'b0 || bif.done !== 1'b0 || bif.error !== 1'b0) begin errors++; $display("FAIL rst_flags got busy=%b done=%b error=%b exp=000", bif.busy, bif.done, bif.error); end
        checks++; if (bif.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", bif.in_ready); end
        checks++; if (bif.word_count !== 6'd0) begin errors++; $display("FAIL rst_word_count got=%0d exp=0", bif.word_count); end
        checks++; if (bif.instruction !== 32'h0) begin errors++; $display("FAIL rst_fetch got=%08h exp=0", bif.instruction); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_load();
        do_reset();
        pulse_start(6'd3);
        checks++; if (bif.busy !== 1'b1 || bif.in_ready !== 1'b1 || bif.cpu_reset !== 1'b1) begin errors++; $display("FAIL basic_enter_load got busy=%b rdy=%b cpu_rst=%b exp=111", bif.busy, bif.in_ready, bif.cpu_reset); end
        send_word(W0);
        send_word(W1);
        checks++; if (bif.cpu_reset !== 1'b1 || bif.word_count !== 6'd2) begin errors++; $display("FAIL basic_mid got cpu_rst=%b wc=%0d exp 1/2", bif.cpu_reset, bif.word_count); end
        send_word(W2);
`ifdef LOADER_CHECKSUM_EN
        checks++; if (bif.cpu_reset !== 1'b1 || bif.in_ready !== 1'b1) begin errors++; $display("FAIL basic_wait_trailer got cpu_rst=%b rdy=%b exp 1/1", bif.cpu_reset, bif.in_ready); end
        send_word(CSUM);
`endif
        checks++; if (bif.cpu_reset !== 1'b0) begin errors++; $display("FAIL basic_cpu_release got=%b exp=0", bif.cpu_reset); end
        checks++; if (bif.done !== 1'b1 || bif.busy !== 1'b0 || bif.in_ready !== 1'b0) begin errors++; $display("FAIL basic_run_flags got done=%b busy=%b rdy=%b exp=100", bif.done, bif.busy, bif.in_ready); end
        checks++; if (bif.word_count !== 6'd3) begin errors++; $display("FAIL basic_word_count got=%0d exp=3", bif.word_count); end
        bif.pc = 32'd0;   #1; checks++; if (bif.instruction !== W0) begin errors++; $display("FAIL fetch_pc0 got=%08h exp=%08h", bif.instruction, W0); end
        bif.pc = 32'd4;   #1; checks++; if (bif.instruction !== W1) begin errors++; $display("FAIL fetch_pc4 got=%08h exp=%08h", bif.instruction, W1); end
        bif.pc = 32'd8;   #1; checks++; if (bif.instruction !== W2) begin errors++; $display("FAIL fetch_pc8 got=%08h exp=%08h", bif.instruction, W2); end
        bif.pc = 32'd12;  #1; checks++; if (bif.instruction !== 32'h0) begin errors++; $display("FAIL fetch_pc12 got=%08h exp=0", bif.instruction); end
        bif.pc = 32'd2;   #1; checks++; if (bif.instruction !== 32'h0) begin errors++; $display("FAIL fetch_misaligned got=%08h exp=0", bif.instruction); end
        bif.pc = 32'd128; #1; checks++; if (bif.instruction !== 32'h0) begin errors++; $display("FAIL fetch_range got=%08h exp=0", bif.instruction); end
        bif.pc = 32'd0;
    endtask

    task automatic test_backpressure();
        logic [31:0] prog [3];
        prog[0] = W0; prog[1] = W1; prog[2] = W2;
        do_reset();
        pulse_start(6'd3);
        for (int i = 0; i < 3; i++) begin
            checks++; if (bif.word_count !== 6'(i) || bif.in_ready !== 1'b1) begin errors++; $display("FAIL bp_pre_word%0d got wc=%0d rdy=%b exp wc=%0d rdy=1", i, bif.word_count, bif.in_ready, i); end
            send_word(prog[i]);
            if (i < 2) begin
                for (int g = 0; g < 2; g++) begin
                    @(posedge clk); #1;
                    checks++; if (bif.word_count !== 6'(i + 1) || bif.in_ready !== 1'b1) begin errors++; $display("FAIL bp_gap%0d_%0d got wc=%0d rdy=%b exp wc=%0d rdy=1", i, g, bif.word_count, bif.in_ready, i + 1); end
                end
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_word(CSUM);
`endif
        checks++; if (bif.word_count !== 6'd3 || bif.done !== 1'b1) begin errors++; $display("FAIL bp_end got wc=%0d done=%b exp 3/1", bif.word_count, bif.done); end
        for (int i = 0; i < 3; i++) begin
            bif.pc = 32'(i * 4); #1;
            checks++; if (bif.instruction !== prog[i]) begin errors++; $display("FAIL bp_fetch%0d got=%08h exp=%08h", i, bif.instruction, prog[i]); end
        end
        bif.pc = 32'd0;
    endtask

    task automatic test_bad_len();
        do_reset();
        pulse_start(6'd0);
        checks++; if (bif.error !== 1'b1 || bif.cpu_reset !== 1'b1) begin errors++; $display("FAIL badlen0 got err=%b cpu_rst=%b exp 1/1", bif.error, bif.cpu_reset); end
        do_reset();
        pulse_start(6'd33);
        checks++; if (bif.error !== 1'b1 || bif.cpu_reset !== 1'b1 || bif.in_ready !== 1'b0) begin errors++; $display("FAIL badlen33 got err=%b cpu_rst=%b rdy=%b exp 1/1/0", bif.error, bif.cpu_reset, bif.in_ready); end
        @(posedge clk); #1;
        checks++; if (bif.error !== 1'b1) begin errors++; $display("FAIL badlen_sticky got=%b exp=1", bif.error); end
        pulse_start(6'd1);
        checks++; if (bif.error !== 1'b0 || bif.busy !== 1'b1) begin errors++; $display("FAIL badlen_recover got err=%b busy=%b exp 0/1", bif.error, bif.busy); end
        send_word(W2);
`ifdef LOADER_CHECKSUM_EN
        send_word(W2);
`endif
        checks++; if (bif.done !== 1'b1 || bif.cpu_reset !== 1'b0) begin errors++; $display("FAIL badlen_run got done=%b cpu_rst=%b exp 1/0", bif.done, bif.cpu_reset); end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        pulse_start(6'd3);
        send_word(W0);
        send_word(W1);
        bif.pc = 32'd4; #1;
        checks++; if (bif.instruction !== W1) begin errors++; $display("FAIL midrst_prefetch got=%08h exp=%08h", bif.instruction, W1); end
        reset = 1'b1;
        #1;
        checks++; if (bif.instruction !== 32'h0) begin errors++; $display("FAIL midrst_fetch4 got=%08h exp=0", bif.instruction); end
        bif.pc = 32'd0; #1;
        checks++; if (bif.instruction !== 32'h0) begin errors++; $display("FAIL midrst_fetch0 got=%08h exp=0", bif.instruction); end
        checks++; if (bif.cpu_reset !== 1'b1 || bif.word_count !== 6'd0 || bif.busy !== 1'b0 || bif.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_state got cpu_rst=%b wc=%0d busy=%b rdy=%b exp 1/0/0/0", bif.cpu_reset, bif.word_count, bif.busy, bif.in_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reload();
        do_reset();
        pulse_start(6'd1);
        send_word(W2);
`ifdef LOADER_CHECKSUM_EN
        send_word(W2);
`endif
        checks++; if (bif.done !== 1'b1 || bif.instruction !== W2) begin errors++; $display("FAIL reload_first got done=%b instr=%08h exp 1/%08h", bif.done, bif.instruction, W2); end
        pulse_start(6'd1);
        checks++; if (bif.cpu_reset !== 1'b1 || bif.done !== 1'b0 || bif.busy !== 1'b1) begin errors++; $display("FAIL reload_hold got cpu_rst=%b done=%b busy=%b exp 1/0/1", bif.cpu_reset, bif.done, bif.busy); end
        checks++; if (bif.instruction !== 32'h0) begin errors++; $display("FAIL reload_cleared got=%08h exp=0", bif.instruction); end
        send_word(W0);
`ifdef LOADER_CHECKSUM_EN
        send_word(W0);
`endif
        checks++; if (bif.cpu_reset !== 1'b0 || bif.instruction !== W0) begin errors++; $display("FAIL reload_second got cpu_rst=%b instr=%08h exp 0/%08h", bif.cpu_reset, bif.instruction, W0); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        pulse_start(6'd3);
        send_word(W0); send_word(W1); send_word(W2);
        send_word(CSUM);
        checks++; if (bif.done !== 1'b1 || bif.error !== 1'b0) begin errors++; $display("FAIL csum_good got done=%b err=%b exp 1/0", bif.done, bif.error); end
        do_reset();
        pulse_start(6'd3);
        send_word(W0); send_word(W1); send_word(W2);
        send_word(32'h40c18012);
        checks++; if (bif.error !== 1'b1 || bif.cpu_reset !== 1'b1 || bif.done !== 1'b0) begin errors++; $display("FAIL csum_bad got err=%b cpu_rst=%b done=%b exp 1/1/0", bif.error, bif.cpu_reset, bif.done); end
        bif.pc = 32'd4; #1;
        checks++; if (bif.instruction !== W1) begin errors++; $display("FAIL csum_kept got=%08h exp=%08h", bif.instruction, W1); end
        bif.pc = 32'd0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bif.load_start = 1'b0;
        bif.load_len   = '0;
        bif.in_valid   = 1'b0;
        bif.in_data    = '0;
        bif.pc         = '0;
        test_reset();
        test_basic_load();
        test_backpressure();
        test_bad_len();
        test_reset_mid_load();
        test_reload();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
